// File: rtl/output_arbiter_if.sv
// rtl/output_arbiter_if.sv - request/flit/grant bundle between crossbar inputs and one output arbiter
interface output_arbiter_if #(
  parameter int PORTS = 4
) ();
  localparam int IW = $clog2(PORTS);

  logic [PORTS-1:0] hdr_req;
  logic [PORTS-1:0] flit_valid;
  logic [PORTS-1:0] flit_tail;
  logic             dn_ack;
  logic [PORTS-1:0] grant;
  logic [IW-1:0]    grant_idx;

  modport master (
    output hdr_req, flit_valid, flit_tail, dn_ack,
    input  grant, grant_idx
  );

  modport slave (
    input  hdr_req, flit_valid, flit_tail, dn_ack,
    output grant, grant_idx
  );
endinterface

// File: rtl/output_arbiter.sv
// rtl/output_arbiter.sv - round-robin wormhole arbiter for one crossbar output, with stall watchdog
module output_arbiter #(
  parameter int PORTS     = 4,
  parameter int MAX_STALL = 64,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  output_arbiter_if.slave    arb,
  output logic               busy,
  output logic               pkt_done,
  output logic               timeout,
  output logic [CNT_W-1:0]   pkt_count
);
  localparam int IW = $clog2(PORTS);
  localparam int SW = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);
  localparam logic [SW-1:0] STALL_SAT  = SW'(MAX_STALL);
  localparam logic [SW-1:0] STALL_LAST = SW'((MAX_STALL < 1) ? 0 : MAX_STALL - 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state, state_nxt;
  logic [IW-1:0]    owner, owner_nxt;
  logic [IW-1:0]    ptr, ptr_nxt;
  logic [SW-1:0]    stall_cnt, stall_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             done_nxt, tmo_nxt;
  logic [IW-1:0]    winner;
  logic             found;
  logic             move, stall_exp;

  // Scan starts at ptr so the previous owner is considered last.
  always_comb begin
    logic [IW-1:0] idx;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < PORTS; k++) begin
      idx = ptr + IW'(k);
      if (!found && arb.hdr_req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign move      = arb.flit_valid[owner] && arb.dn_ack;
  assign stall_exp = (MAX_STALL != 0) && (stall_cnt == STALL_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= '0;
      ptr       <= '0;
      stall_cnt <= '0;
      pkt_count <= '0;
      pkt_done  <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      ptr       <= ptr_nxt;
      stall_cnt <= stall_nxt;
      pkt_count <= cnt_nxt;
      pkt_done  <= done_nxt;
      timeout   <= tmo_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    stall_nxt = stall_cnt;
    cnt_nxt   = pkt_count;
    done_nxt  = 1'b0;
    tmo_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (found && arb.dn_ack) begin
          state_nxt = LOCKED;
          owner_nxt = winner;
          stall_nxt = '0;
        end
      end
      LOCKED: begin
        // A tail move takes precedence over an expiring watchdog.
        if (move) begin
          if (arb.flit_tail[owner]) begin
            state_nxt = IDLE;
            ptr_nxt   = owner + IW'(1);
            done_nxt  = 1'b1;
            cnt_nxt   = pkt_count + CNT_W'(1);
          end else begin
            stall_nxt = '0;
          end
        end else if (stall_exp) begin
          state_nxt = IDLE;
          ptr_nxt   = owner + IW'(1);
          tmo_nxt   = 1'b1;
        end else if (stall_cnt != STALL_SAT) begin
          stall_nxt = stall_cnt + SW'(1);
        end
      end
    endcase
  end

  // Grant is gated by rst so it drops with the asynchronous reset even while requests persist.
  always_comb begin
    arb.grant     = '0;
    arb.grant_idx = '0;
    busy          = 1'b0;
    if (!rst) begin
      if (state == LOCKED) begin
        arb.grant[owner] = 1'b1;
        arb.grant_idx    = owner;
        busy             = 1'b1;
      end else if (found) begin
        arb.grant[winner] = 1'b1;
        arb.grant_idx     = winner;
      end
    end
  end
endmodule

// File: tb/tb_output_arbiter.sv
// tb/tb_output_arbiter.sv - directed checks of output_arbiter arbitration, locking, watchdog and reset
module tb_output_arbiter;
  logic        clk;
  logic        rst;
  logic        busy, pkt_done, timeout;
  logic [15:0] pkt_count;
  logic        nw_busy, nw_pkt_done, nw_timeout;
  logic [15:0] nw_pkt_count;
  int          checks;
  int          errors;
  int          tmo_seen;
  int          busy_drop;
  logic [3:0]  fair_exp [10];

  output_arbiter_if #(.PORTS(4)) bus ();
  output_arbiter_if #(.PORTS(4)) nw ();

  output_arbiter #(.PORTS(4), .MAX_STALL(8), .CNT_W(16)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .arb       (bus.slave),
    .busy      (busy),
    .pkt_done  (pkt_done),
    .timeout   (timeout),
    .pkt_count (pkt_count)
  );

  output_arbiter #(.PORTS(4), .MAX_STALL(0), .CNT_W(16)) u_nw (
    .clk       (clk),
    .rst       (rst),
    .arb       (nw.slave),
    .busy      (nw_busy),
    .pkt_done  (nw_pkt_done),
    .timeout   (nw_timeout),
    .pkt_count (nw_pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input logic [3:0] h, input logic [3:0] v, input logic [3:0] t, input logic a);
    bus.hdr_req    = h;
    bus.flit_valid = v;
    bus.flit_tail  = t;
    bus.dn_ack     = a;
    #1;
  endtask

  task automatic set_n(input logic [3:0] h, input logic [3:0] v, input logic [3:0] t, input logic a);
    nw.hdr_req    = h;
    nw.flit_valid = v;
    nw.flit_tail  = t;
    nw.dn_ack     = a;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    fair_exp = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                 4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0001};
    rst = 1'b1;
    set_n(4'b0000, 4'b0000, 4'b0000, 1'b0);
    set_m(4'b0100, 4'b0100, 4'b0000, 1'b1);
    repeat (2) @(posedge clk);
    #3;
    chk("rst_grant", bus.grant, 0);
    chk("rst_idx", bus.grant_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", pkt_done, 0);
    chk("rst_tmo", timeout, 0);
    chk("rst_cnt", pkt_count, 0);
    tick();
    rst = 1'b0;

    // header backpressure: winner held, nothing locks
    for (int i = 0; i < 5; i++) begin
      set_m(4'b0011, 4'b0011, 4'b0000, 1'b0);
      chk("bp_grant", bus.grant, 4'b0001);
      chk("bp_busy", busy, 0);
      tick();
    end
    set_m(4'b0011, 4'b0011, 4'b0000, 1'b1);
    chk("bp_ack_grant", bus.grant, 4'b0001);
    chk("bp_ack_idx", bus.grant_idx, 0);
    tick();
    set_m(4'b0010, 4'b0011, 4'b0001, 1'b1);
    chk("bp_lock_busy", busy, 1);
    chk("bp_lock_grant", bus.grant, 4'b0001);
    tick();
    set_m(4'b0000, 4'b0000, 4'b0000, 1'b0);
    chk("bp_done", pkt_done, 1);
    chk("bp_cnt", pkt_count, 1);
    chk("bp_idle", busy, 0);
    tick();

    // single 5-flit packet on input 2
    set_m(4'b0100, 4'b0100, 4'b0000, 1'b1);
    chk("sr_grant", bus.grant, 4'b0100);
    chk("sr_idx", bus.grant_idx, 2);
    chk("sr_busy_pre", busy, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      set_m(4'b0000, 4'b0100, (i == 3) ? 4'b0100 : 4'b0000, 1'b1);
      chk("sr_lock_grant", bus.grant, 4'b0100);
      chk("sr_lock_busy", busy, 1);
      chk("sr_no_done", pkt_done, 0);
      tick();
    end
    set_m(4'b0000, 4'b0000, 4'b0000, 1'b0);
    chk("sr_done", pkt_done, 1);
    chk("sr_cnt", pkt_count, 2);
    chk("sr_busy_off", busy, 0);
    tick();
    set_m(4'b1111, 4'b1111, 4'b0000, 1'b0);
    chk("sr_done_once", pkt_done, 0);
    chk("sr_ptr_grant", bus.grant, 4'b1000);
    chk("sr_ptr_idx", bus.grant_idx, 3);
    tick();

    // input 1 locked while input 3 requests
    set_m(4'b0010, 4'b0010, 4'b0000, 1'b1);
    chk("iv_grant", bus.grant, 4'b0010);
    tick();
    set_m(4'b1000, 4'b1010, 4'b0000, 1'b1);
    chk("iv_hold1", bus.grant, 4'b0010);
    tick();
    set_m(4'b1000, 4'b1010, 4'b0000, 1'b1);
    chk("iv_hold2", bus.grant, 4'b0010);
    tick();
    set_m(4'b1000, 4'b1010, 4'b0010, 1'b1);
    chk("iv_hold_tail", bus.grant, 4'b0010);
    tick();
    set_m(4'b1000, 4'b1000, 4'b0000, 1'b0);
    chk("iv_next_grant", bus.grant, 4'b1000);
    chk("iv_busy", busy, 0);
    chk("iv_done", pkt_done, 1);
    chk("iv_cnt", pkt_count, 3);
    tick();

    // watchdog expiry after 8 stalled cycles
    set_m(4'b0001, 4'b0001, 4'b0000, 1'b1);
    chk("wd_grant", bus.grant, 4'b0001);
    tick();
    for (int k = 1; k <= 8; k++) begin
      set_m(4'b0000, 4'b0000, 4'b0000, 1'b1);
      chk("wd_busy", busy, 1);
      chk("wd_tmo_early", timeout, 0);
      tick();
    end
    set_m(4'b0000, 4'b0000, 4'b0000, 1'b0);
    chk("wd_tmo_pulse", timeout, 1);
    chk("wd_busy_off", busy, 0);
    chk("wd_no_done", pkt_done, 0);
    chk("wd_cnt", pkt_count, 3);
    tick();
    set_m(4'b0000, 4'b0000, 4'b0000, 1'b0);
    chk("wd_tmo_once", timeout, 0);

    // tail arrives on the cycle the watchdog would fire
    set_m(4'b0010, 4'b0010, 4'b0000, 1'b1);
    chk("tw_grant", bus.grant, 4'b0010);
    tick();
    for (int k = 0; k < 7; k++) begin
      set_m(4'b0000, 4'b0000, 4'b0000, 1'b1);
      tick();
    end
    set_m(4'b0000, 4'b0010, 4'b0010, 1'b1);
    chk("tw_busy", busy, 1);
    tick();
    set_m(4'b0000, 4'b0000, 4'b0000, 1'b0);
    chk("tw_done", pkt_done, 1);
    chk("tw_tmo", timeout, 0);
    chk("tw_cnt", pkt_count, 4);
    tick();

    // reach pkt_count=5, lock input 3, then reset mid-packet
    set_m(4'b0100, 4'b0100, 4'b0000, 1'b1);
    tick();
    set_m(4'b0000, 4'b0100, 4'b0100, 1'b1);
    tick();
    set_m(4'b0000, 4'b0000, 4'b0000, 1'b0);
    chk("rm_cnt5", pkt_count, 5);
    tick();
    set_m(4'b1000, 4'b1000, 4'b0000, 1'b1);
    chk("rm_grant", bus.grant, 4'b1000);
    tick();
    set_m(4'b1100, 4'b1000, 4'b0000, 1'b0);
    chk("rm_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("rm_rst_grant", bus.grant, 0);
    chk("rm_rst_idx", bus.grant_idx, 0);
    chk("rm_rst_busy", busy, 0);
    chk("rm_rst_cnt", pkt_count, 0);
    tick();
    rst = 1'b0;
    set_m(4'b1100, 4'b1100, 4'b0000, 1'b0);
    chk("rm_after_grant", bus.grant, 4'b0100);
    chk("rm_after_done", pkt_done, 0);
    chk("rm_after_tmo", timeout, 0);
    tick();

    // fairness: every input requesting 2-flit packets continuously
    for (int i = 0; i < 10; i++) begin
      set_m(4'b1111, 4'b1111, 4'b1111, 1'b1);
      chk("fair_grant", bus.grant, fair_exp[i]);
      tick();
    end
    set_m(4'b0000, 4'b0000, 4'b0000, 1'b0);
    chk("fair_cnt", pkt_count, 5);

    // watchdog disabled: lock survives 1000 stalled cycles
    set_n(4'b0001, 4'b0001, 4'b0000, 1'b1);
    chk("nw_grant", nw.grant, 4'b0001);
    tick();
    tmo_seen  = 0;
    busy_drop = 0;
    for (int k = 0; k < 1000; k++) begin
      set_n(4'b0000, 4'b0000, 4'b0000, 1'b1);
      if (nw_timeout) tmo_seen++;
      if (!nw_busy) busy_drop++;
      tick();
    end
    set_n(4'b0000, 4'b0000, 4'b0000, 1'b1);
    chk("nw_no_timeout", tmo_seen, 0);
    chk("nw_busy_held", busy_drop, 0);
    chk("nw_still_grant", nw.grant, 4'b0001);
    set_n(4'b0000, 4'b0001, 4'b0001, 1'b1);
    tick();
    set_n(4'b0000, 4'b0000, 4'b0000, 1'b0);
    chk("nw_done", nw_pkt_done, 1);
    chk("nw_cnt", nw_pkt_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
